// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the load unit, ROB commit path, data memory and mem_port_arbiter.
// slave: arbiter side. master: requester/memory side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              flush;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [1:0]        ld_type;
    logic              ld_grant;
    logic              ld_done;
    logic [DATA_W-1:0] ld_data;
    logic              st_req;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [1:0]        st_type;
    logic              st_grant;
    logic              st_done;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [1:0]        mem_type;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  flush, ld_req, ld_addr, ld_type, st_req, st_addr, st_data, st_type,
               mem_ack, mem_rdata,
        output ld_grant, ld_done, ld_data, st_grant, st_done,
               mem_req, mem_we, mem_addr, mem_wdata, mem_type
    );

    modport master (
        output flush, ld_req, ld_addr, ld_type, st_req, st_addr, st_data, st_type,
               mem_ack, mem_rdata,
        input  ld_grant, ld_done, ld_data, st_grant, st_done,
               mem_req, mem_we, mem_addr, mem_wdata, mem_type
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single data-memory port shared by speculative loads and committed stores; stores have priority.
// Define MEM_ARB_STARVE_EN to let a waiting load win after STARVE_LIMIT consecutive store grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic               clock,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBusyLd, StBusySt} state_e;

    state_e            state_q;
    logic              drop_q;
    logic              ld_grant_q, ld_done_q, st_grant_q, st_done_q;
    logic [DATA_W-1:0] ld_data_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [1:0]        mem_type_q;

    logic ld_ok, ld_wins, grant_ld, grant_st;

`ifdef MEM_ARB_STARVE_EN
    localparam int unsigned StreakW = $clog2(STARVE_LIMIT + 1);
    localparam logic [StreakW-1:0] StreakMax = StreakW'(STARVE_LIMIT);
    logic [StreakW-1:0] streak_q;
`endif

    always_comb begin
        ld_ok = bus.ld_req && !bus.flush;
`ifdef MEM_ARB_STARVE_EN
        ld_wins = ld_ok && (!bus.st_req || streak_q == StreakMax);
`else
        ld_wins = ld_ok && !bus.st_req;
`endif
        grant_st = (state_q == StIdle) && bus.st_req && !ld_wins;
        grant_ld = (state_q == StIdle) && ld_wins;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            drop_q      <= 1'b0;
            ld_grant_q  <= 1'b0;
            ld_done_q   <= 1'b0;
            st_grant_q  <= 1'b0;
            st_done_q   <= 1'b0;
            ld_data_q   <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_type_q  <= '0;
        end else begin
            ld_grant_q <= 1'b0;
            ld_done_q  <= 1'b0;
            st_grant_q <= 1'b0;
            st_done_q  <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (grant_st) begin
                        state_q     <= StBusySt;
                        st_grant_q  <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= bus.st_addr;
                        mem_wdata_q <= bus.st_data;
                        mem_type_q  <= bus.st_type;
                    end else if (grant_ld) begin
                        state_q     <= StBusyLd;
                        drop_q      <= 1'b0;
                        ld_grant_q  <= 1'b1;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.ld_addr;
                        mem_wdata_q <= '0;
                        mem_type_q  <= bus.ld_type;
                    end
                end
                StBusyLd: begin
                    if (bus.mem_ack) begin
                        state_q   <= StIdle;
                        mem_req_q <= 1'b0;
                        drop_q    <= 1'b0;
                        // A squash on the completing edge still kills the result.
                        if (!drop_q && !bus.flush) begin
                            ld_done_q <= 1'b1;
                            ld_data_q <= bus.mem_rdata;
                        end
                    end else if (bus.flush) begin
                        drop_q <= 1'b1;
                    end
                end
                StBusySt: begin
                    if (bus.mem_ack) begin
                        state_q   <= StIdle;
                        mem_req_q <= 1'b0;
                        st_done_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MEM_ARB_STARVE_EN
    // Counts store wins over a waiting load; bounded because reaching StreakMax forces a load win.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            streak_q <= '0;
        end else if (bus.flush) begin
            streak_q <= '0;
        end else if (state_q == StIdle) begin
            if (grant_ld || !bus.ld_req) begin
                streak_q <= '0;
            end else if (grant_st) begin
                streak_q <= streak_q + 1'b1;
            end
        end
    end
`endif

    assign bus.ld_grant  = ld_grant_q;
    assign bus.ld_done   = ld_done_q;
    assign bus.ld_data   = ld_data_q;
    assign bus.st_grant  = st_grant_q;
    assign bus.st_done   = st_done_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_type  = mem_type_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data-memory port between the load unit (speculative reads) and the reorder buffer's commit-time store writes. Sits between `loadUnit`/`reorderBuffer` and `dataMemory`. It grants one transaction at a time and holds the memory request until the memory acknowledges. It drops load results squashed by a ROB flush. Committed stores get priority, with an optional guard against load starvation.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, consecutive store grants allowed while a load waits (used only with the starvation guard)

Ports:
- `clock` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-high; clears all state
- `flush` in 1: ROB mispredict squash (`resetAll`)
- `ld_req` in 1: load unit requests a read; held until `ld_grant`
- `ld_addr` in ADDR_W: read address
- `ld_type` in 2: access size (0 byte, 1 half, 2 word)
- `ld_grant` out 1: one-cycle pulse; load accepted
- `ld_done` out 1: one-cycle pulse; `ld_data` valid
- `ld_data` out DATA_W: registered read data
- `st_req` in 1: ROB commit requests a write; held until `st_grant`
- `st_addr` in ADDR_W, `st_data` in DATA_W, `st_type` in 2: write address, data and size
- `st_grant` out 1: one-cycle pulse; store accepted
- `st_done` out 1: one-cycle pulse; write completed
- `mem_req` out 1, `mem_we` out 1: memory request and write enable
- `mem_addr` out ADDR_W, `mem_wdata` out DATA_W, `mem_type` out 2: latched transaction fields
- `mem_ack` in 1: memory completion, one cycle
- `mem_rdata` in DATA_W: read data, valid with `mem_ack`

## Operation
- FSM states:
  - IDLE: no transaction.
  - BUSY_LD: read outstanding.
  - BUSY_ST: write outstanding.
- IDLE arbitration at each posedge:
  - `st_req` only → BUSY_ST.
  - `ld_req && !flush` only → BUSY_LD.
  - Both → store wins, unless the starvation guard fires (see Configuration).
- On grant, the winner's address, data and type are latched into `mem_*`. `mem_we` = 1 for a store.
- BUSY_x: `mem_req` stays high and the `mem_*` fields stay stable until `mem_ack` is sampled. On that edge:
  - `mem_req` goes to 0 and the state returns to IDLE.
  - The matching `*_done` pulses.
  - For a load, `ld_data` ← `mem_rdata`.
- Flush:
  - In IDLE: a flush on the same edge blocks a load grant.
  - In BUSY_LD: the drop flag is set. The memory read still completes, but `ld_done` is suppressed and `ld_data` is not updated.
  - Stores are never affected by flush.
- `mem_ack` seen in IDLE is ignored.
- Reset: state IDLE, drop flag 0, streak counter 0. All outputs are 0, including `ld_data` and the `mem_*` fields. Reset mid-transaction abandons it; `mem_req` falls asynchronously.

## Timing
- Grant decision and `mem_req` rise at the same edge N. The `*_grant` pulse is high during N→N+1.
- The requester deasserts its request after seeing the grant. A request still high at the next IDLE edge is treated as a new request.
- `mem_ack` sampled at edge M gives `*_done` high during M→M+1, and the state is IDLE from M.
- The earliest next grant is at edge M+1, so back-to-back transactions have one idle cycle between them.
- Minimum transaction, with `mem_ack` on the cycle after grant: grant at N, done at N+1.
- `flush` and `mem_ack` on the same edge in BUSY_LD: `ld_done` is suppressed.

## Configuration
- `MEM_ARB_STARVE_EN` defined:
  - A streak counter (width `$clog2(STARVE_LIMIT+1)`) increments on each store grant made while `ld_req` is high.
  - It clears on a load grant, on `flush`, or on an IDLE edge with `ld_req` low.
  - When the counter equals `STARVE_LIMIT` and both requests are present, the load wins.
- `MEM_ARB_STARVE_EN` undefined: fixed store priority, no counter logic.

## Test plan
- Single load at 0x10, `mem_ack` 3 cycles after grant with rdata 0x1234 → `ld_grant` at N, `mem_req` high 3 cycles, `ld_done` at N+3 with `ld_data`=0x1234, `mem_we`=0.
- `ld_req` and `st_req` both high at the same edge → `st_grant` first. `ld_grant` at the edge after `st_done`, one cycle after IDLE is entered.
- Flush 1 cycle after a load grant, `mem_ack` later → `mem_req` held until ack, no `ld_done`, `ld_data` unchanged. Flush coincident with `ld_req` in IDLE → no grant.
- With `MEM_ARB_STARVE_EN` and `STARVE_LIMIT`=2: continuous `st_req` plus `ld_req` → grant order is store, store, load, store. Without the macro → stores only while `st_req` persists.
- Assert `reset` while BUSY_ST → `mem_req`, `st_done` and `st_grant` go to 0 immediately. After release, a new `ld_req` is granted at the first edge.
- Stray `mem_ack` in IDLE → no `*_done` pulse and no state change.
